// File: rtl/oled_pkg.sv
// Shared constants for the OLED layer compositor: screen geometry, RGB565 colours and
// the flash state encoding.
package oled_pkg;

   localparam int WIDTH     = 96;
   localparam int HEIGHT    = 64;
   localparam int PIX_COUNT = WIDTH * HEIGHT;

   localparam logic [15:0] BLACK  = 16'h0000;
   localparam logic [15:0] YELLOW = 16'hFFE0;
   localparam logic [15:0] RED    = 16'hF800;
   localparam logic [15:0] WHITE  = 16'hFFFF;

   typedef enum logic {
      NORMAL = 1'b0,
      FLASH  = 1'b1
   } flash_state_e;

endpackage

// File: rtl/oled_index_decode.sv
// Registered pixel_index -> (x, y, valid) decode for the 96x64 OLED scan order.
// Out-of-range indices decode to (0, 0) with valid low.
module oled_index_decode
   import oled_pkg::*;
(
   input  logic        basys_clk,
   input  logic        rst_n,
   input  logic [12:0] pixel_index,
   output logic [6:0]  x,
   output logic [6:0]  y,
   output logic        valid
);

   logic [6:0] x_d, x_q;
   logic [6:0] y_d, y_q;
   logic       valid_d, valid_q;
   logic [6:0] row;

   // 96 = 32*3: drop five bits, then divide by 3 as *171>>9, exact for quotients up to 63
   always_comb begin
      row     = 7'(({9'd0, pixel_index[12:5]} * 17'd171) >> 9);
      valid_d = pixel_index < 13'(PIX_COUNT);
      x_d     = '0;
      y_d     = '0;
      if (valid_d) begin
         y_d = row;
         x_d = 7'(pixel_index - 13'(row) * 13'(WIDTH));
      end
   end

   always_ff @(posedge basys_clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q     <= '0;
         y_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         valid_q <= valid_d;
      end
   end

   assign x     = x_q;
   assign y     = y_q;
   assign valid = valid_q;

endmodule

// File: rtl/oled_layer_compositor.sv
// Scan-to-colour stage: decodes pixel_index, aligns it with the drawing layers and composites
// sprite/map/background with a frame-synchronous hit flash. Define LAYER_BORDER_EN for a border layer.
module oled_layer_compositor
   import oled_pkg::*;
#(
   parameter int          LAYER_LAT    = 1,
   parameter logic [15:0] TRANSP       = BLACK,
   parameter logic [15:0] FLASH_COLOR  = RED,
   parameter int          FLASH_FRAMES = 8
`ifdef LAYER_BORDER_EN
   , parameter logic [15:0] BORDER_COLOR = WHITE
`endif
)(
   input  logic        basys_clk,
   input  logic        rst_n,
   input  logic [12:0] pixel_index,
   input  logic        frame_begin,
   input  logic        hit_pulse,
   output logic [6:0]  x,
   output logic [6:0]  y,
   input  logic [15:0] map_data,
   input  logic [15:0] sprite_data,
   output logic [15:0] oled_data,
   output logic        flash_active
);

   // state  | meaning
   // NORMAL | no flash pending or shown
   // FLASH  | flash requested or on screen; cnt_q counts remaining flash frames

`ifdef LAYER_BORDER_EN
   localparam int DW = 15;
`else
   localparam int DW = 1;
`endif

   logic          dec_valid;
   logic [DW-1:0] dly_d;
   logic [DW-1:0] dly_q [LAYER_LAT];
   logic [DW-1:0] al;
   logic          al_valid;

   flash_state_e  state_d, state_q;
   logic [7:0]    cnt_d, cnt_q;
   logic          flash_d, flash_q;
   logic          fb_q;
   logic          fe_rise;
   logic [15:0]   oled_d, oled_q;

   oled_index_decode u_decode (
      .basys_clk   (basys_clk),
      .rst_n       (rst_n),
      .pixel_index (pixel_index),
      .x           (x),
      .y           (y),
      .valid       (dec_valid)
   );

   always_comb begin
`ifdef LAYER_BORDER_EN
      dly_d = {dec_valid, x, y};
`else
      dly_d = dec_valid;
`endif
   end

   always_ff @(posedge basys_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LAYER_LAT; i++) dly_q[i] <= '0;
      end else begin
         dly_q[0] <= dly_d;
         for (int i = 1; i < LAYER_LAT; i++) dly_q[i] <= dly_q[i-1];
      end
   end

   assign al       = dly_q[LAYER_LAT-1];
   assign al_valid = al[DW-1];
   assign fe_rise  = frame_begin & ~fb_q;

   // Countdown starts only once the flash is on screen, so a mid-frame hit still yields FLASH_FRAMES shown frames
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      flash_d = flash_q;
      case (state_q)
         NORMAL: begin
            if (hit_pulse) begin
               state_d = FLASH;
               cnt_d   = 8'(FLASH_FRAMES);
            end
         end
         FLASH: begin
            if (hit_pulse) begin
               cnt_d = 8'(FLASH_FRAMES);
            end else if (fe_rise && flash_q) begin
               cnt_d = cnt_q - 8'd1;
               if (cnt_q == 8'd1) state_d = NORMAL;
            end
         end
         default: state_d = NORMAL;
      endcase
      if (fe_rise) flash_d = (state_d == FLASH);
   end

   always_comb begin
      oled_d = BLACK;
      if (!al_valid) begin
         oled_d = BLACK;
      end
`ifdef LAYER_BORDER_EN
      else if (al[13:7] == 7'd0 || al[13:7] == 7'(WIDTH-1) ||
               al[6:0] == 7'd0 || al[6:0] == 7'(HEIGHT-1)) begin
         oled_d = BORDER_COLOR;
      end
`endif
      else if (sprite_data != TRANSP) begin
         oled_d = sprite_data;
      end else if (map_data != TRANSP) begin
         oled_d = map_data;
      end else begin
         oled_d = flash_q ? FLASH_COLOR : BLACK;
      end
   end

   always_ff @(posedge basys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= NORMAL;
         cnt_q   <= '0;
         flash_q <= 1'b0;
         fb_q    <= 1'b0;
         oled_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         flash_q <= flash_d;
         fb_q    <= frame_begin;
         oled_q  <= oled_d;
      end
   end

   assign oled_data    = oled_q;
   assign flash_active = flash_q;

endmodule
